unif_buf_writer: RTL and testbench
==================================

Name: unif_buf_writer

Overview:
- Write-side counterpart of the unified-buffer patch reader.
- Accepts a stream of 32-bit output-activation beats in row-major HWC byte order. Each beat is 4 consecutive bytes.
- Packs 4 beats into one 128-bit unified-buffer word and issues word writes with lane enables to the buffer RAM.
- Word byte layout matches the reader: word = {din0,din1,din2,din3}; byte offset k sits at bits (15-k)*8.
- Sits between the requantise stage and the unified buffer RAM.

Parameters:
- MAX_IMG_W, 64, maximum layer width in pixels.
- MAX_IMG_H, 64, maximum layer height in pixels.
- MAX_CHANNELS, 64, maximum channels per pixel.
- ADDR_W, $clog2(MAX_IMG_W*MAX_IMG_H*MAX_CHANNELS/4), RAM word address width (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; latches cfg_* and begins a layer write. Honoured only in IDLE or DONE.
- cfg_img_w  in  $clog2(MAX_IMG_W)+1  layer width.
- cfg_img_h  in  $clog2(MAX_IMG_H)+1  layer height.
- cfg_channels  in  $clog2(MAX_CHANNELS)+1  channels; must be a nonzero multiple of 4.
- cfg_base_addr  in  ADDR_W  word address of byte 0 (allows ping-pong regions).
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  32  beat; in_data[31:24] is the lowest-address byte.
- in_last  in  1  producer's end-of-layer marker; used only when the checker is enabled.
- ram_we  out  4  lane write enables; bit 3 = din0 … bit 0 = din3.
- ram_addr  out  ADDR_W  write word address.
- ram_din0, ram_din1, ram_din2, ram_din3  out  32 each  lane data.
- busy  out  1  high in FILL.
- done  out  1  high in DONE.
- words_written  out  ADDR_W+1  words issued in the current layer.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: ram_we=0, ram_addr=0, ram_din*=0, in_ready=0, busy=0, done=0, words_written=0, err=0. State returns to IDLE.
- States: IDLE, FILL, DONE.
- IDLE/DONE, on start:
  - Latch cfg.
  - total_beats = W*H*C/4, computed once in a register. Width $clog2(MAX_IMG_W*MAX_IMG_H*MAX_CHANNELS/4)+1, no truncation.
  - Clear beat_cnt, lane, words_written and err. Set wr_addr = cfg_base_addr.
  - If total_beats==0 or C[1:0]!=0: go to DONE with no writes and set err.
  - Otherwise go to FILL.
- FILL:
  - in_ready=1 combinationally in this state. Throughput is 1 beat/cycle with no bubbles at word boundaries.
  - On an accepted beat, store it into lane register [lane] and increment lane mod 4 and beat_cnt.
- Write issue: outputs are registered, so the write appears the cycle after the triggering beat. A write issues when either:
  - lane==3 is accepted: ram_we=4'b1111, ram_din* = the 4 lanes, ram_addr=wr_addr. Then wr_addr++ and words_written++.
  - the final beat (beat_cnt==total_beats-1) is accepted with lane<3 (partial word): ram_we has the filled lanes only, MSB first (lane 0 only → 4'b1000). Unfilled din lanes drive 0.
- ram_we is a 1-cycle pulse. The RAM always accepts; there is no backpressure from the RAM.
- Lane registers restart at lane 0 in the same cycle a word is handed to the output registers. There is no double-buffer hazard.
- The final beat moves the state to DONE. done rises in the same cycle as the final ram_we.
- DONE holds until start; in_ready=0.
- start in FILL is ignored.
- wr_addr reaching 2^ADDR_W-1 wraps to 0 (caller's responsibility; not flagged).
- Reset mid-layer: discard partial lanes, issue no write; ram_we=0 from the next edge.

Optional Feature:
- Macro UNIF_BUF_WR_CHECK_EN.
- Defined: err is set sticky in either case:
  - in_last asserted on an accepted beat other than the final one.
  - in_last deasserted on the final beat.
  - Data is still written normally.
- Also defined: an assertion fires if in_valid drops while in FILL with in_ready high and data pending (simulation only).
- Undefined: in_last is ignored and err reflects only the cfg error.

Decomposition:
- Package unif_buf_pkg holds the shared contract with the reader:
  - WORD_BYTES=16, LANES=4.
  - addr_t typedef and the lane/byte-offset mapping constant.
  - The state enum for the writer.
- One sub-module, unif_buf_lane_packer: the lane counter, the 4×32 lane registers and the we-mask generation.
- The FSM, counters and address stay in the top.

Test Plan:
1. W=2,H=2,C=4, base=10, beats A0..A3 back-to-back → one write addr=10, we=1111, din0..3=A0..A3; done=1 same cycle; words_written=1.
2. W=3,H=1,C=4, beats B0..B2 → write we=1110, din0=B0, din1=B1, din2=B2, din3=0; done.
3. W=4,H=4,C=8, base=0, in_valid randomly toggled → 32 beats, 8 writes at addr 0..7 in order, data matches a reference byte model; reader-style extraction of byte (15-k)*8 returns byte k.
4. Reset after 2 beats of a layer → no ram_we ever asserted; in_ready=0, busy=0 next cycle; restart writes from base.
5. start during FILL ignored; start in DONE with base=100 → first write at 100. C=6 → DONE immediately, err=1, no writes.
6. With UNIF_BUF_WR_CHECK_EN: in_last on beat 2 of 4 → err=1 sticky, all 4 beats still written; without the macro → err=0.

Source files
------------

// File: rtl/unif_buf_pkg.sv
// Shared contract between the unified-buffer patch reader and the writer:
// word geometry, lane/byte mapping helpers and the writer state encoding.
package unif_buf_pkg;

    localparam int WORD_BYTES = 16;
    localparam int LANES      = 4;
    localparam int BEAT_BYTES = WORD_BYTES / LANES;

    // Default layer limits; the writer derives the same address width from its own parameters.
    localparam int UB_MAX_IMG_W    = 64;
    localparam int UB_MAX_IMG_H    = 64;
    localparam int UB_MAX_CHANNELS = 64;
    localparam int UB_ADDR_W       = $clog2(UB_MAX_IMG_W * UB_MAX_IMG_H * UB_MAX_CHANNELS / LANES);

    typedef logic [UB_ADDR_W-1:0] addr_t;

    // Byte offset k of a word lives at bits [(15-k)*8 +: 8].
    function automatic int byte_lsb(input int k);
        return (WORD_BYTES - 1 - k) * 8;
    endfunction

    // Lane 0 (din0) owns the MSB of the write-enable mask.
    function automatic int lane_we_bit(input int lane);
        return LANES - 1 - lane;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/unif_buf_lane_packer.sv
// Collects 32-bit beats into four lane registers and presents a complete
// (or final partial) word together with its MSB-first lane enable mask.
module unif_buf_lane_packer
    import unif_buf_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   beat_fire,
    input  logic                   beat_final,
    input  logic [31:0]            beat_data,
    output logic                   word_fire,
    output logic [LANES-1:0]       word_we,
    output logic [LANES-1:0][31:0] word_data
);

    logic [1:0]  lane_reg;
    logic [31:0] lane_data_reg [LANES];

    // A word is handed off when the last lane fills or the layer's final beat arrives.
    assign word_fire = beat_fire && ((lane_reg == 2'd3) || beat_final);

    // Lane pointer: restarts at 0 in the same cycle a word is handed off.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane_reg <= 2'd0;
        end else if (word_fire) begin
            lane_reg <= 2'd0;
        end else if (beat_fire) begin
            lane_reg <= lane_reg + 2'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            // Capture the beat into its lane; stale contents are masked below.
            always_ff @(posedge clk) begin
                if (beat_fire && (lane_reg == 2'(gi))) begin
                    lane_data_reg[gi] <= beat_data;
                end
            end

            // Earlier lanes come from registers, the current lane bypasses the
            // incoming beat so a word is complete without a bubble.
            assign word_we[lane_we_bit(gi)] = (2'(gi) <= lane_reg);
            assign word_data[gi] = (2'(gi) <  lane_reg) ? lane_data_reg[gi] :
                                   (2'(gi) == lane_reg) ? beat_data : 32'd0;
        end
    endgenerate

endmodule

// File: rtl/unif_buf_writer.sv
// Unified-buffer writer: packs a stream of 32-bit HWC beats into 128-bit
// words and issues registered lane-enabled writes to the buffer RAM.
// Optional build macro UNIF_BUF_WR_CHECK_EN enables in_last protocol
// checking (sticky err) and a simulation assertion against mid-word stalls.
module unif_buf_writer
    import unif_buf_pkg::*;
#(
    parameter  int MAX_IMG_W    = 64,
    parameter  int MAX_IMG_H    = 64,
    parameter  int MAX_CHANNELS = 64,
    localparam int ADDR_W       = $clog2(MAX_IMG_W * MAX_IMG_H * MAX_CHANNELS / 4)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [$clog2(MAX_IMG_W):0]     cfg_img_w,
    input  logic [$clog2(MAX_IMG_H):0]     cfg_img_h,
    input  logic [$clog2(MAX_CHANNELS):0]  cfg_channels,
    input  logic [ADDR_W-1:0]              cfg_base_addr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_data,
    input  logic                           in_last,
    output logic [3:0]                     ram_we,
    output logic [ADDR_W-1:0]              ram_addr,
    output logic [31:0]                    ram_din0,
    output logic [31:0]                    ram_din1,
    output logic [31:0]                    ram_din2,
    output logic [31:0]                    ram_din3,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_W:0]                words_written,
    output logic                           err
);

    localparam int W_W    = $clog2(MAX_IMG_W) + 1;
    localparam int H_W    = $clog2(MAX_IMG_H) + 1;
    localparam int C_W    = $clog2(MAX_CHANNELS) + 1;
    localparam int PROD_W = W_W + H_W + C_W;
    localparam int TB_W   = $clog2(MAX_IMG_W * MAX_IMG_H * MAX_CHANNELS / 4) + 1;

    wr_state_t              state_reg;
    logic [TB_W-1:0]        total_beats_reg;
    logic [TB_W-1:0]        beat_cnt_reg;
    logic [ADDR_W-1:0]      wr_addr_reg;
    logic [ADDR_W:0]        words_written_reg;
    logic                   err_reg;
    logic [3:0]             ram_we_reg;
    logic [ADDR_W-1:0]      ram_addr_reg;
    logic [LANES-1:0][31:0] ram_din_reg;

    logic [PROD_W-1:0]      layer_bytes;
    logic [TB_W-1:0]        total_beats_next;
    logic                   cfg_bad;
    logic                   start_ok;
    logic                   beat_fire;
    logic                   beat_final;
    logic                   word_fire;
    logic [LANES-1:0]       word_we;
    logic [LANES-1:0][31:0] word_data;

    // Full-width product so no layer inside the limits is truncated; /4 drops the low bits.
    assign layer_bytes      = PROD_W'(cfg_img_w) * PROD_W'(cfg_img_h) * PROD_W'(cfg_channels);
    assign total_beats_next = layer_bytes[TB_W+1:2];
    assign cfg_bad          = (total_beats_next == '0) || (cfg_channels[1:0] != 2'b00);

    assign start_ok   = start && (state_reg != ST_FILL);
    assign in_ready   = (state_reg == ST_FILL);
    assign beat_fire  = in_valid && in_ready;
    assign beat_final = (beat_cnt_reg == total_beats_reg - TB_W'(1));

    unif_buf_lane_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .beat_fire  (beat_fire),
        .beat_final (beat_final),
        .beat_data  (in_data),
        .word_fire  (word_fire),
        .word_we    (word_we),
        .word_data  (word_data)
    );

    // Layer FSM, beat/word counters, write address and registered RAM port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            total_beats_reg   <= '0;
            beat_cnt_reg      <= '0;
            wr_addr_reg       <= '0;
            words_written_reg <= '0;
            err_reg           <= 1'b0;
            ram_we_reg        <= 4'b0000;
            ram_addr_reg      <= '0;
            ram_din_reg       <= '0;
        end else begin
            ram_we_reg <= 4'b0000;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        total_beats_reg   <= total_beats_next;
                        beat_cnt_reg      <= '0;
                        words_written_reg <= '0;
                        wr_addr_reg       <= cfg_base_addr;
                        err_reg           <= cfg_bad;
                        state_reg         <= cfg_bad ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (beat_fire) begin
                        beat_cnt_reg <= beat_cnt_reg + TB_W'(1);
                        if (word_fire) begin
                            ram_we_reg        <= word_we;
                            ram_addr_reg      <= wr_addr_reg;
                            ram_din_reg       <= word_data;
                            wr_addr_reg       <= wr_addr_reg + ADDR_W'(1);
                            words_written_reg <= words_written_reg + (ADDR_W+1)'(1);
                        end
                        if (beat_final) begin
                            state_reg <= ST_DONE;
                        end
`ifdef UNIF_BUF_WR_CHECK_EN
                        // in_last must mark exactly the final beat of the layer.
                        if (in_last != beat_final) begin
                            err_reg <= 1'b1;
                        end
`endif
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef UNIF_BUF_WR_CHECK_EN
    // The producer must not stall in the middle of a word (beat_cnt mod 4 is the lane).
    a_no_mid_word_drop: assert property (
        @(posedge clk) disable iff (reset)
        (state_reg == ST_FILL && $past(in_valid && in_ready) && beat_cnt_reg[1:0] != 2'd0)
        |-> in_valid
    );
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    assign ram_we        = ram_we_reg;
    assign ram_addr      = ram_addr_reg;
    assign ram_din0      = ram_din_reg[0];
    assign ram_din1      = ram_din_reg[1];
    assign ram_din2      = ram_din_reg[2];
    assign ram_din3      = ram_din_reg[3];
    assign busy          = (state_reg == ST_FILL);
    assign done          = (state_reg == ST_DONE);
    assign words_written = words_written_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_unif_buf_writer.sv
// Scoreboard bench for unif_buf_writer: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_unif_buf_writer;

    localparam int ADDR_W = 16;

`ifdef UNIF_BUF_WR_CHECK_EN
    localparam logic EXP_CHK_ERR = 1'b1;
`else
    localparam logic EXP_CHK_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [6:0]        cfg_img_w = '0;
    logic [6:0]        cfg_img_h = '0;
    logic [6:0]        cfg_channels = '0;
    logic [ADDR_W-1:0] cfg_base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = '0;
    logic              in_last = 1'b0;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din0, ram_din1, ram_din2, ram_din3;
    logic              busy, done, err;
    logic [ADDR_W:0]   words_written;

    unif_buf_writer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_img_w     (cfg_img_w),
        .cfg_img_h     (cfg_img_h),
        .cfg_channels  (cfg_channels),
        .cfg_base_addr (cfg_base_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din0      (ram_din0),
        .ram_din1      (ram_din1),
        .ram_din2      (ram_din2),
        .ram_din3      (ram_din3),
        .busy          (busy),
        .done          (done),
        .words_written (words_written),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        we;
        logic [127:0]      word;
        logic              fin;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [127:0] cap_mem [256];
    logic [7:0]   ref_bytes [128];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int addr, input logic [3:0] we, input logic [127:0] word, input logic fin);
        exp_t e;
        e.addr = ADDR_W'(addr);
        e.we   = we;
        e.word = word;
        e.fin  = fin;
        exp_q.push_back(e);
    endtask

    // Every DUT write is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (ram_we != 4'b0000) begin
            $display("write addr=%0d we=%b data=%h_%h_%h_%h done=%b",
                     ram_addr, ram_we, ram_din0, ram_din1, ram_din2, ram_din3, done);
            cap_mem[ram_addr[7:0]] = {ram_din0, ram_din1, ram_din2, ram_din3};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d we %b, expected no write", ram_addr, ram_we);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 128'(ram_addr), 128'(mon_e.addr));
                check("wr_we", 128'(ram_we), 128'(mon_e.we));
                check("wr_data", {ram_din0, ram_din1, ram_din2, ram_din3}, mon_e.word);
                check("wr_done", 128'(done), 128'(mon_e.fin));
            end
        end
    end

    task automatic start_layer(input int w, input int h, input int c, input int base);
        cfg_img_w     = 7'(w);
        cfg_img_h     = 7'(h);
        cfg_channels  = 7'(c);
        cfg_base_addr = ADDR_W'(base);
        start         = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready", 128'(in_ready), 128'(1'b1));
        if (in_ready) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_layer(input int exp_words);
        @(negedge clk); #1;
        check("done", 128'(done), 128'(1'b1));
        check("busy_low", 128'(busy), 128'(1'b0));
        check("words_written", 128'(words_written), 128'(exp_words));
        check("sb_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] w;
        logic         gap_ok;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_we", 128'(ram_we), 128'(0));
        check("rst_ram_addr", 128'(ram_addr), 128'(0));
        check("rst_ram_din", {ram_din0, ram_din1, ram_din2, ram_din3}, 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_words", 128'(words_written), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: single full word at base 10
        start_layer(2, 2, 4, 10);
        check("t1_busy", 128'(busy), 128'(1'b1));
        push_exp(10, 4'b1111, 128'hA0000001_A0000002_A0000003_A0000004, 1'b1);
        send_beat(32'hA0000001, 1'b0);
        send_beat(32'hA0000002, 1'b0);
        send_beat(32'hA0000003, 1'b0);
        send_beat(32'hA0000004, 1'b1);
        finish_layer(1);
        check("t1_err", 128'(err), 128'(0));
        check("t1_in_ready", 128'(in_ready), 128'(0));

        // 2: partial final word, three lanes
        start_layer(3, 1, 4, 40);
        push_exp(40, 4'b1110, 128'hB0000001_B0000002_B0000003_00000000, 1'b1);
        send_beat(32'hB0000001, 1'b0);
        send_beat(32'hB0000002, 1'b0);
        send_beat(32'hB0000003, 1'b1);
        finish_layer(1);

        // 3: 32 beats with gaps, reference byte model
        for (int k = 0; k < 128; k++) ref_bytes[k] = 8'((k * 7 + 3) & 8'hFF);
        start_layer(4, 4, 8, 0);
        for (int j = 0; j < 8; j++) begin
            w = '0;
            for (int k = 0; k < 16; k++) w[(15 - k) * 8 +: 8] = ref_bytes[16 * j + k];
            push_exp(j, 4'b1111, w, j == 7);
        end
        for (int i = 0; i < 32; i++) begin
`ifdef UNIF_BUF_WR_CHECK_EN
            gap_ok = (i % 4 == 0);
`else
            gap_ok = 1'b1;
`endif
            if (gap_ok) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            send_beat({ref_bytes[4*i], ref_bytes[4*i+1], ref_bytes[4*i+2], ref_bytes[4*i+3]}, i == 31);
        end
        finish_layer(8);
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 16; k++) begin
                check("t3_byte_extract", 128'(cap_mem[j][(15 - k) * 8 +: 8]), 128'(ref_bytes[16 * j + k]));
            end
        end

        // 4: reset mid-layer discards lanes, restart from base
        start_layer(2, 2, 4, 20);
        send_beat(32'hDEAD0001, 1'b0);
        send_beat(32'hDEAD0002, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t4_in_ready", 128'(in_ready), 128'(0));
        check("t4_busy", 128'(busy), 128'(0));
        check("t4_ram_we", 128'(ram_we), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start_layer(2, 2, 4, 20);
        push_exp(20, 4'b1111, 128'h11111111_22222222_33333333_44444444, 1'b1);
        send_beat(32'h11111111, 1'b0);
        send_beat(32'h22222222, 1'b0);
        send_beat(32'h33333333, 1'b0);
        send_beat(32'h44444444, 1'b1);
        finish_layer(1);

        // 5: start in FILL ignored; start in DONE honoured; bad channel count
        start_layer(2, 2, 4, 30);
        push_exp(30, 4'b1111, 128'hC0000001_C0000002_C0000003_C0000004, 1'b1);
        send_beat(32'hC0000001, 1'b0);
        cfg_base_addr = ADDR_W'(50);
        start = 1'b1;
        send_beat(32'hC0000002, 1'b0);
        start = 1'b0;
        send_beat(32'hC0000003, 1'b0);
        send_beat(32'hC0000004, 1'b1);
        finish_layer(1);
        start_layer(2, 2, 4, 100);
        push_exp(100, 4'b1111, 128'hD0000001_D0000002_D0000003_D0000004, 1'b1);
        send_beat(32'hD0000001, 1'b0);
        send_beat(32'hD0000002, 1'b0);
        send_beat(32'hD0000003, 1'b0);
        send_beat(32'hD0000004, 1'b1);
        finish_layer(1);
        start_layer(2, 2, 6, 60);
        check("t5_c6_done", 128'(done), 128'(1));
        check("t5_c6_err", 128'(err), 128'(1));
        check("t5_c6_busy", 128'(busy), 128'(0));
        check("t5_c6_words", 128'(words_written), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        check("t5_c6_sb_empty", 128'(exp_q.size()), 128'(0));

        // 6: early in_last
        start_layer(2, 2, 4, 200);
        check("t6_err_cleared", 128'(err), 128'(0));
        push_exp(200, 4'b1111, 128'hE0000001_E0000002_E0000003_E0000004, 1'b1);
        send_beat(32'hE0000001, 1'b0);
        send_beat(32'hE0000002, 1'b1);
        send_beat(32'hE0000003, 1'b0);
        send_beat(32'hE0000004, 1'b1);
        finish_layer(1);
        check("t6_err", 128'(err), 128'(EXP_CHK_ERR));
        repeat (3) @(posedge clk);
        #1;
        check("t6_err_sticky", 128'(err), 128'(EXP_CHK_ERR));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
